// File: rtl/mem_arbiter.sv
// Two-master arbiter for the byte-wide SoC RAM port: registered req/gnt handshake,
// round-robin on contention, bounded tenure with lock override, one dead cycle per handover.
module mem_arbiter #(
  parameter int unsigned addr_width = 9,
  parameter int unsigned max_burst  = 16,
  parameter int unsigned cnt_width  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  output logic                  m0_gnt,
  input  logic [addr_width-1:0] m0_raddr,
  input  logic [addr_width-1:0] m0_waddr,
  input  logic [7:0]            m0_data_in,
  input  logic                  m0_write,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  input  logic [addr_width-1:0] m1_raddr,
  input  logic [addr_width-1:0] m1_waddr,
  input  logic [7:0]            m1_data_in,
  input  logic                  m1_write,
  output logic [7:0]            m_data_out,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write,
  input  logic [7:0]            mem_data_out
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, SWITCH} state_t;

  localparam logic [cnt_width-1:0] CNT_TOP = cnt_width'(max_burst - 1);

  state_t               state, state_nxt;
  logic                 next_owner, next_owner_nxt;
  logic                 last, last_nxt;
  logic [cnt_width-1:0] cnt, cnt_nxt;

  // Per-state view of the current owner and the other master
  logic owner, own_req, own_lock, oth_req, pick_req, alt_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      next_owner <= 1'b0;
      last       <= 1'b1;
      cnt        <= '0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
    end else begin
      state      <= state_nxt;
      next_owner <= next_owner_nxt;
      last       <= last_nxt;
      cnt        <= cnt_nxt;
      m0_gnt     <= (state_nxt == OWN0);
      m1_gnt     <= (state_nxt == OWN1);
    end
  end

  always_comb begin
    state_nxt      = state;
    next_owner_nxt = next_owner;
    last_nxt       = last;
    cnt_nxt        = cnt;
    owner          = (state == OWN1);
    own_req        = owner ? m1_req  : m0_req;
    own_lock       = owner ? m1_lock : m0_lock;
    oth_req        = owner ? m0_req  : m1_req;
    pick_req       = next_owner ? m1_req : m0_req;
    alt_req        = next_owner ? m0_req : m1_req;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (m0_req && m1_req) state_nxt = last ? OWN0 : OWN1;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          // Voluntary release wins over a preemption due in the same cycle
          last_nxt = owner;
          cnt_nxt  = '0;
          if (oth_req) begin
            state_nxt      = SWITCH;
            next_owner_nxt = ~owner;
          end else begin
            state_nxt = IDLE;
          end
        end else if (!oth_req) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_TOP) begin
          if (!own_lock) begin
            state_nxt      = SWITCH;
            next_owner_nxt = ~owner;
            last_nxt       = owner;
            cnt_nxt        = '0;
          end
        end else begin
          cnt_nxt = cnt + cnt_width'(1);
        end
      end
      default: begin
        cnt_nxt = '0;
        if (pick_req)     state_nxt = next_owner ? OWN1 : OWN0;
        else if (alt_req) state_nxt = next_owner ? OWN0 : OWN1;
        else              state_nxt = IDLE;
      end
    endcase
  end

  // RAM port mux: owner passes straight through; writes never escape during reset
  always_comb begin
    mem_raddr   = '0;
    mem_waddr   = '0;
    mem_data_in = '0;
    mem_write   = 1'b0;
    case (state)
      OWN0: begin
        mem_raddr   = m0_raddr;
        mem_waddr   = m0_waddr;
        mem_data_in = m0_data_in;
        mem_write   = m0_write & ~reset;
      end
      OWN1: begin
        mem_raddr   = m1_raddr;
        mem_waddr   = m1_waddr;
        mem_data_in = m1_data_in;
        mem_write   = m1_write & ~reset;
      end
      default: ;
    endcase
  end

  assign m_data_out = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 2-cycle-latency byte RAM model behind it.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req, m0_lock, m0_write, m1_req, m1_lock, m1_write;
  logic       m0_gnt, m1_gnt;
  logic [8:0] m0_raddr, m0_waddr, m1_raddr, m1_waddr;
  logic [7:0] m0_data_in, m1_data_in;
  logic [7:0] m_data_out;
  logic [8:0] mem_raddr, mem_waddr;
  logic [7:0] mem_data_in, mem_data_out, rd1;
  logic       mem_write;
  logic       ram_init;
  logic [7:0] ram [512];

  int n_cmp = 0;
  int n_err = 0;
  int hold;

  always #5 clk = ~clk;

  mem_arbiter #(.addr_width(9), .max_burst(16), .cnt_width(5)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
    .m0_raddr(m0_raddr), .m0_waddr(m0_waddr), .m0_data_in(m0_data_in), .m0_write(m0_write),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
    .m1_raddr(m1_raddr), .m1_waddr(m1_waddr), .m1_data_in(m1_data_in), .m1_write(m1_write),
    .m_data_out(m_data_out),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  // RAM: address in cycle n, data on mem_data_out in cycle n+2
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
      ram[9'h012] <= 8'hA5;
      ram[9'h1F0] <= 8'h77;
    end else if (mem_write) begin
      ram[mem_waddr] <= mem_data_in;
    end
    rd1          <= ram[mem_raddr];
    mem_data_out <= rd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_lock = 0; m0_write = 0; m0_raddr = '0; m0_waddr = '0; m0_data_in = '0;
    m1_req = 0; m1_lock = 0; m1_write = 0; m1_raddr = '0; m1_waddr = '0; m1_data_in = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL reset_write: got %b want 0", mem_write); end
    n_cmp++; if ({mem_raddr, mem_waddr, mem_data_in} !== 26'h0) begin n_err++; $display("FAIL reset_bus: got %h want 0", {mem_raddr, mem_waddr, mem_data_in}); end
    reset = 0;
  endtask

  task automatic test_grant_read();
    m0_req = 1; m0_raddr = 9'h012;
    #1;
    n_cmp++; if (m0_gnt !== 1'b0) begin n_err++; $display("FAIL gnt_early: got %b want 0", m0_gnt); end
    tick();
    n_cmp++; if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL gnt_m0: got %b want 1", m0_gnt); end
    n_cmp++; if (mem_raddr !== 9'h012) begin n_err++; $display("FAIL raddr_mux: got %h want 012", mem_raddr); end
    tick();
    tick();
    n_cmp++; if (m_data_out !== 8'hA5) begin n_err++; $display("FAIL read_data: got %h want a5", m_data_out); end
    m0_req = 0;
    tick();
    n_cmp++; if (m0_gnt !== 1'b0) begin n_err++; $display("FAIL release_m0: got %b want 0", m0_gnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_req = 1; m1_req = 1;
    tick();
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_err++; $display("FAIL rr_first: got %b want 10", {m0_gnt, m1_gnt}); end
    m0_req = 0; m1_write = 1; m1_waddr = 9'h0AA; m1_data_in = 8'h11;
    tick();
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_err++; $display("FAIL rr_switch_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rr_switch_write: got %b want 0", mem_write); end
    m1_write = 0;
    tick();
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_err++; $display("FAIL rr_handover: got %b want 01", {m0_gnt, m1_gnt}); end
    m1_req = 0;
    tick();
    m0_req = 1;
    tick();
    m0_req = 0;
    tick();
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_err++; $display("FAIL rr_idle: got %b want 00", {m0_gnt, m1_gnt}); end
    m0_req = 1; m1_req = 1;
    tick();
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_err++; $display("FAIL rr_second: got %b want 01", {m0_gnt, m1_gnt}); end
    clear_inputs();
    tick();
  endtask

  task automatic test_preempt();
    do_reset();
    m0_req = 1; m1_req = 1;
    tick();
    hold = 0;
    while (m0_gnt === 1'b1 && hold < 100) begin
      hold++;
      tick();
    end
    n_cmp++; if (hold !== 16) begin n_err++; $display("FAIL preempt_tenure: got %0d want 16", hold); end
    n_cmp++; if (m1_gnt !== 1'b0) begin n_err++; $display("FAIL preempt_switch: got %b want 0", m1_gnt); end
    tick();
    n_cmp++; if (m1_gnt !== 1'b1) begin n_err++; $display("FAIL preempt_m1: got %b want 1", m1_gnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    m0_req = 1; m0_lock = 1; m1_req = 1;
    tick();
    repeat (39) tick();
    n_cmp++; if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL lock_hold: got %b want 1", m0_gnt); end
    m0_lock = 0;
    tick();
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_err++; $display("FAIL lock_release: got %b want 00", {m0_gnt, m1_gnt}); end
    tick();
    n_cmp++; if (m1_gnt !== 1'b1) begin n_err++; $display("FAIL lock_m1: got %b want 1", m1_gnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_drop();
    do_reset();
    m0_req = 1;
    tick();
    m1_req = 1; m1_write = 1; m1_waddr = 9'h1F0; m1_data_in = 8'h3C;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL drop_write%0d: got %b want 0", i, mem_write); end
      tick();
    end
    n_cmp++; if (ram[9'h1F0] !== 8'h77) begin n_err++; $display("FAIL drop_ram: got %h want 77", ram[9'h1F0]); end
    m0_req = 0;
    tick();
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL drop_switch: got %b want 0", mem_write); end
    tick();
    n_cmp++; if ({m1_gnt, mem_write} !== 2'b11) begin n_err++; $display("FAIL own1_write: got %b want 11", {m1_gnt, mem_write}); end
    tick();
    m1_write = 0; m1_raddr = 9'h1F0;
    tick();
    tick();
    n_cmp++; if (m_data_out !== 8'h3C) begin n_err++; $display("FAIL readback: got %h want 3c", m_data_out); end
  endtask

  task automatic test_reset_mid();
    m1_write = 1; m1_data_in = 8'h99;
    #1;
    n_cmp++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL mid_owner_write: got %b want 1", mem_write); end
    reset = 1;
    #1;
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL mid_reset_write: got %b want 0", mem_write); end
    tick();
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_err++; $display("FAIL mid_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    n_cmp++; if (ram[9'h1F0] !== 8'h3C) begin n_err++; $display("FAIL mid_ram: got %h want 3c", ram[9'h1F0]); end
    reset = 0; m1_req = 0; m1_write = 0;
    tick();
    n_cmp++; if ({m0_gnt, m1_gnt, mem_raddr} !== 11'h0) begin n_err++; $display("FAIL mid_idle: got %h want 0", {m0_gnt, m1_gnt, mem_raddr}); end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    ram_init = 1;
    tick();
    ram_init = 0;
    test_reset();
    test_grant_read();
    test_round_robin();
    test_preempt();
    test_lock();
    test_write_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide SoC RAM port (raddr/waddr/data_in/data_out/write) between two masters: master 0 (cpu core) and master 1 (loader/DMA engine).
- Registered req/gnt handshake per master, round-robin on contention, bounded tenure with lock override, one dead cycle on every ownership change.
- Sits between the masters and the RAM; read latency to the RAM is unchanged.

Parameters:
addr_width, 9, width of RAM byte addresses
max_burst, 16, cycles an owner may keep the grant while the other master is requesting (minimum 2)
cnt_width, 5, width of tenure counter; must hold max_burst

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
m0_req  input  1  master 0 requests the RAM port
m0_lock  input  1  master 0 forbids preemption (multi-byte load/store in progress)
m0_gnt  output  1  master 0 owns the RAM port
m0_raddr  input  addr_width  master 0 read address
m0_waddr  input  addr_width  master 0 write address
m0_data_in  input  8  master 0 write data
m0_write  input  1  master 0 write strobe
m1_req, m1_lock, m1_gnt, m1_raddr, m1_waddr, m1_data_in, m1_write  same as master 0, for master 1
m_data_out  output  8  RAM read data, broadcast to both masters
mem_raddr  output  addr_width  to RAM
mem_waddr  output  addr_width  to RAM
mem_data_in  output  8  to RAM
mem_write  output  1  to RAM
mem_data_out  input  8  from RAM

Behaviour:
- States: IDLE, OWN0, OWN1, SWITCH. Registers: state, next_owner, last (last master served), tenure counter cnt.
- Reset: state IDLE, m0_gnt=m1_gnt=0, cnt=0, last=1, so master 0 wins the first contention. Outputs: mem_raddr, mem_waddr, mem_data_in = 0; mem_write = 0.
- m0_gnt = (state==OWN0); m1_gnt = (state==OWN1). Both are registered, so they are never high together.
- Mux: in OWNx, mem_* = mx_* combinationally, adding no latency. In IDLE/SWITCH, mem_* = 0 and mem_write = 0.
- mem_write is also forced 0 whenever reset is high. A write strobe from a non-owner is dropped and never queued.
- m_data_out = mem_data_out, always passed through. Masters keep their own 2-cycle read latency (address at n, data valid at n+2).
- IDLE:
  - Only m0_req -> OWN0.
  - Only m1_req -> OWN1.
  - Both -> OWN of the master != last.
  - None -> stay IDLE.
  - Grant is visible the cycle after req is first seen high.
- OWNx, x = owner, y = other master; cnt cleared on entry:
  - mx_req low: if my_req high -> SWITCH with next_owner=y; else -> IDLE. last=x in both cases.
  - mx_req high, my_req high: cnt increments each cycle.
  - Preemption: when cnt == max_burst-1 and mx_lock low -> SWITCH with next_owner=y, last=x.
  - If mx_lock is high at that point, cnt saturates at max_burst-1 and preemption happens on the first cycle lock is low.
  - my_req low: cnt holds 0 and the owner keeps the grant indefinitely.
- SWITCH: exactly one cycle, no grant, mem_write=0.
  - -> OWN(next_owner) if that master's req is still high.
  - Else -> OWN(other) if its req is high.
  - Else -> IDLE.
- A master must hold its req until it sees gnt. It must sample gnt before driving its write strobe, and it must drop req or lock only at operation boundaries.
- Simultaneous events:
  - Owner drops req in the same cycle its preemption threshold is reached: treated as a voluntary release (last=x, SWITCH).
  - Both reqs rise in the same cycle in IDLE: round-robin per last.
- Reset mid-operation: grant is removed on the next edge, any in-flight multi-byte transfer is abandoned, and no write reaches the RAM in the reset cycle.
- Lock without gnt has no effect.

Test Plan:
- Reset, then m0_req=1 only -> m0_gnt=1 one cycle later. m0_raddr=0x012 appears on mem_raddr the same cycle; RAM byte 0xA5 at 0x012 returns on m_data_out 2 cycles after the address.
- m0_req and m1_req both rise in IDLE after reset -> m0_gnt first. m0 releases, and both re-request after IDLE -> m1 granted (round-robin). Exactly one SWITCH cycle sits between the grants, with mem_write=0.
- m0 owns and m1_req is held, max_burst=16, m0_lock=0 -> m0_gnt drops after 16 cycles of contention, SWITCH for 1 cycle, m1_gnt=1.
- Same as the previous case but m0_lock=1 for 40 cycles -> m0 keeps the grant for 40 cycles, then is preempted on the first unlocked cycle.
- m1 drives m1_write=1, waddr=0x1F0, data=0x3C while m0 owns -> mem_write stays 0 and RAM 0x1F0 is unchanged. After m1 is granted the write lands and reads back as 0x3C.
- reset asserted while m1 owns with m1_write=1 -> mem_write=0 in the reset cycle, both gnts are 0 the next cycle, and state is IDLE.
